// File: rtl/aes_gcm_input_sequencer.sv
// AES-GCM input sequencer: turns IV/length and host AAD/plaintext blocks into one registered stage-1 stream.
// Optional i_last consistency check enabled by defining AES_GCM_SEQ_LAST_CHECK_EN.
module aes_gcm_input_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [95:0]  i_iv,
  input  logic [127:0] i_instance_size,
  input  logic         i_valid,
  input  logic [127:0] i_data,
  input  logic         i_last,
  output logic         o_ready,
  output logic [95:0]  o_iv,
  output logic [127:0] o_instance_size,
  output logic [127:0] o_aad,
  output logic [127:0] o_plain_text,
  output logic [2:0]   o_phase,
  output logic         o_new_instance,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_err
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_AAD, S_TEXT, S_LEN} state_e;

  localparam logic [2:0] PH_IDLE   = 3'b111;
  localparam logic [2:0] PH_INIT   = 3'b000;
  localparam logic [2:0] PH_AAD    = 3'b001;
  localparam logic [2:0] PH_TEXT   = 3'b010;
  localparam logic [2:0] PH_LEN    = 3'b011;
  localparam logic [2:0] PH_BUBBLE = 3'b100;

  // Block count = ceil(len/128); only 32 bits of the quotient are kept.
  function automatic logic [31:0] block_count(input logic [38:0] len_bits);
    return len_bits[38:7] + {31'd0, |len_bits[6:0]};
  endfunction

  function automatic logic [127:0] trim_tail(input logic [127:0] d, input logic [6:0] rem);
    if (rem == 7'd0) return d;
    return d & ~({128{1'b1}} << rem);
  endfunction

  state_e       state_q, state_d;
  logic [31:0]  a_cnt_q, a_cnt_d, c_cnt_q, c_cnt_d;
  logic [6:0]   a_rem_q, a_rem_d, c_rem_q, c_rem_d;
  logic [95:0]  iv_q, iv_d;
  logic [127:0] size_q, size_d, aad_q, aad_d, pt_q, pt_d;
  logic [2:0]   phase_q, phase_d;
  logic         new_inst_q, new_inst_d, valid_q, valid_d;
  logic         ready_q, ready_d, busy_q, busy_d;
  logic         accept, a_last, c_last;

  // ready_q is high exactly when state_q is AAD or TEXT, so accept implies one of those states.
  assign accept = ready_q & i_valid;
  assign a_last = (a_cnt_q == 32'd1);
  assign c_last = (c_cnt_q == 32'd1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    a_cnt_d    = a_cnt_q;
    c_cnt_d    = c_cnt_q;
    a_rem_d    = a_rem_q;
    c_rem_d    = c_rem_q;
    iv_d       = iv_q;
    size_d     = size_q;
    aad_d      = aad_q;
    pt_d       = pt_q;
    phase_d    = PH_IDLE;
    new_inst_d = 1'b0;
    valid_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_INIT;
          iv_d    = i_iv;
          size_d  = i_instance_size;
          a_cnt_d = block_count(i_instance_size[102:64]);
          c_cnt_d = block_count(i_instance_size[38:0]);
          a_rem_d = i_instance_size[70:64];
          c_rem_d = i_instance_size[6:0];
        end
      end
      S_INIT: begin
        phase_d    = PH_INIT;
        new_inst_d = 1'b1;
        valid_d    = 1'b1;
        if (a_cnt_q != 32'd0)      state_d = S_AAD;
        else if (c_cnt_q != 32'd0) state_d = S_TEXT;
        else                       state_d = S_LEN;
      end
      S_AAD: begin
        phase_d = PH_BUBBLE;
        if (accept) begin
          phase_d = PH_AAD;
          valid_d = 1'b1;
          aad_d   = a_last ? trim_tail(i_data, a_rem_q) : i_data;
          pt_d    = '0;
          a_cnt_d = a_cnt_q - 32'd1;
          if (a_last) state_d = (c_cnt_q != 32'd0) ? S_TEXT : S_LEN;
        end
      end
      S_TEXT: begin
        phase_d = PH_BUBBLE;
        if (accept) begin
          phase_d = PH_TEXT;
          valid_d = 1'b1;
          pt_d    = c_last ? trim_tail(i_data, c_rem_q) : i_data;
          aad_d   = '0;
          c_cnt_d = c_cnt_q - 32'd1;
          if (c_last) state_d = S_LEN;
        end
      end
      S_LEN: begin
        phase_d = PH_LEN;
        valid_d = 1'b1;
        aad_d   = size_q;
        pt_d    = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_AAD) || (state_d == S_TEXT);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every register, data path included, has a reset value so outputs are defined during reset.
    if (rst) begin
      state_q    <= S_IDLE;
      a_cnt_q    <= '0;
      c_cnt_q    <= '0;
      a_rem_q    <= '0;
      c_rem_q    <= '0;
      iv_q       <= '0;
      size_q     <= '0;
      aad_q      <= '0;
      pt_q       <= '0;
      phase_q    <= PH_IDLE;
      new_inst_q <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
      state_q    <= state_d;
      a_cnt_q    <= a_cnt_d;
      c_cnt_q    <= c_cnt_d;
      a_rem_q    <= a_rem_d;
      c_rem_q    <= c_rem_d;
      iv_q       <= iv_d;
      size_q     <= size_d;
      aad_q      <= aad_d;
      pt_q       <= pt_d;
      phase_q    <= phase_d;
      new_inst_q <= new_inst_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

`ifdef AES_GCM_SEQ_LAST_CHECK_EN
  logic err_q, err_d, final_blk;

  always_comb begin
    final_blk = (state_q == S_AAD) ? a_last : c_last;
    err_d     = err_q | (accept & (i_last != final_blk));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign o_err = err_q;
`else
  logic unused_last;
  assign unused_last = i_last;
  assign o_err       = 1'b0;
`endif

  assign o_ready         = ready_q;
  assign o_iv            = iv_q;
  assign o_instance_size = size_q;
  assign o_aad           = aad_q;
  assign o_plain_text    = pt_q;
  assign o_phase         = phase_q;
  assign o_new_instance  = new_inst_q;
  assign o_valid         = valid_q;
  assign o_busy          = busy_q;
endmodule
